// File: rtl/jk_bank_ctrl_pkg.sv
// Shared definitions for the JK bank controller: op encodings, FSM states and
// the expected-result helper used by the readback check.
package jk_bank_ctrl_pkg;

    // Bit 1 of the op selects j and bit 0 selects k for every masked flop.
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_RST  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_APPLY = 2'b01,
        ST_CHECK = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    function automatic logic [31:0] op_result(op_e op, logic [31:0] q, logic [31:0] mask);
        logic [31:0] f;
        f = q;
        case (op)
            OP_HOLD: f = q;
            OP_RST:  f = '0;
            OP_SET:  f = '1;
            OP_TGL:  f = ~q;
            default: f = q;
        endcase
        return (q & ~mask) | (f & mask);
    endfunction

endpackage

// File: rtl/jk_bank_ctrl_jk_ff.sv
// Single JK flip-flop with synchronous active-high reset.
module jk_ff (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven controller for a bank of WIDTH JK flops; one op per handshake.
// Define JK_BANK_CTRL_CHECK_EN to compile in the readback CHECK state and err.
module jk_bank_ctrl
    import jk_bank_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

`ifdef JK_BANK_CTRL_CHECK_EN
    logic [WIDTH-1:0] exp_q;
    logic             err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready = (state == ST_IDLE) && !rst;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        jk_ff u_ff (
            .clk (clk),
            .rst (rst),
            .j   (j[i]),
            .k   (k[i]),
            .q   (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            j     <= '0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef JK_BANK_CTRL_CHECK_EN
            exp_q <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state <= ST_APPLY;
                        busy  <= 1'b1;
                        // j/k registered here so they are live for exactly the APPLY cycle.
                        j     <= cmd_mask & {WIDTH{cmd_op[1]}};
                        k     <= cmd_mask & {WIDTH{cmd_op[0]}};
`ifdef JK_BANK_CTRL_CHECK_EN
                        exp_q <= WIDTH'(op_result(op_e'(cmd_op), 32'(q), 32'(cmd_mask)));
`endif
                    end
                end
                ST_APPLY: begin
                    j <= '0;
                    k <= '0;
`ifdef JK_BANK_CTRL_CHECK_EN
                    state <= ST_CHECK;
`else
                    state <= ST_DONE;
                    done  <= 1'b1;
`endif
                end
`ifdef JK_BANK_CTRL_CHECK_EN
                ST_CHECK: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                    err_q <= (q != exp_q);
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
`ifdef JK_BANK_CTRL_CHECK_EN
                    err_q <= 1'b0;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed, table-driven bench for jk_bank_ctrl (WIDTH=4); follows JK_BANK_CTRL_CHECK_EN.
module tb_jk_bank_ctrl;

`ifdef JK_BANK_CTRL_CHECK_EN
    localparam int LAT     = 3;
    localparam bit CHK_BLD = 1'b1;
`else
    localparam int LAT     = 2;
    localparam bit CHK_BLD = 1'b0;
`endif
    localparam int PERIOD = LAT + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_mask;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [3:0] model_q;

    typedef struct {
        logic [1:0] op;
        logic [3:0] mask;
        logic [3:0] q_after;
    } vec_t;
    vec_t vecs[8];

    jk_bank_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-bit JK characteristic applied to the masked bits.
    function automatic logic [3:0] jk_model(logic [3:0] cur, logic [1:0] op, logic [3:0] mask);
        logic [3:0] nxt;
        nxt = cur;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                if (op == 2'b01)      nxt[b] = 1'b0;
                else if (op == 2'b10) nxt[b] = 1'b1;
                else if (op == 2'b11) nxt[b] = !cur[b];
            end
        end
        return nxt;
    endfunction

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] mask,
                           input logic [3:0] exp_q, input logic exp_err);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_mask  = ~mask;
        check("busy_cycle1", busy, 1);
        check("ready_cycle1", cmd_ready, 0);
        check("done_cycle1", done, 0);
        n = 1;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, LAT);
        check("q_at_done", q, exp_q);
        check("err_at_done", err, exp_err);
        check("busy_at_done", busy, 1);
        check("ready_at_done", cmd_ready, 0);
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("ready_after_done", cmd_ready, 1);
        check("busy_after_done", busy, 0);
        check("err_after_done", err, 0);
    endtask

    initial begin
        logic [1:0] ops[3];
        int last_acc;
        int acc_cnt;
        int n;
        bit saw_done;

        vecs[0] = '{2'b10, 4'b1111, 4'b1111};
        vecs[1] = '{2'b11, 4'b0101, 4'b1010};
        vecs[2] = '{2'b01, 4'b1000, 4'b0010};
        vecs[3] = '{2'b00, 4'b1111, 4'b0010};
        vecs[4] = '{2'b10, 4'b0000, 4'b0010};
        vecs[5] = '{2'b11, 4'b1111, 4'b1101};
        vecs[6] = '{2'b10, 4'b0011, 4'b1111};
        vecs[7] = '{2'b01, 4'b0110, 4'b1001};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_mask  = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_ready_low", cmd_ready, 0);
        check("reset_q", q, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        // rst together with cmd_valid: must not be accepted.
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_mask  = 4'hF;
        @(negedge clk);
        check("rst_beats_valid_busy", busy, 0);
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_first_cycle", cmd_ready, 1);
        check("q_after_reset", q, 0);
        @(negedge clk);

        model_q = 4'h0;
        for (int i = 0; i < 8; i++) begin
            check("vec_model_agrees", jk_model(model_q, vecs[i].op, vecs[i].mask), vecs[i].q_after);
            run_cmd(vecs[i].op, vecs[i].mask, vecs[i].q_after, 1'b0);
            model_q = vecs[i].q_after;
        end

        // Continuous cmd_valid with the op changing every cycle.
        ops[0] = 2'b10;
        ops[1] = 2'b11;
        ops[2] = 2'b01;
        last_acc = -1;
        acc_cnt  = 0;
        for (int c = 0; c < 12; c++) begin
            cmd_valid = 1'b1;
            cmd_op    = ops[c % 3];
            cmd_mask  = 4'b1011;
            if (cmd_ready) begin
                if (last_acc < 0) check("stream_first_acc", c, 0);
                else              check("stream_gap", c - last_acc, PERIOD);
                last_acc = c;
                acc_cnt++;
                model_q = jk_model(model_q, ops[c % 3], 4'b1011);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stream_idle", cmd_ready, 1);
        check("stream_acc_count", acc_cnt, (12 + PERIOD - 1) / PERIOD);
        check("stream_q", q, model_q);

        // rst during APPLY of a set command.
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_mask  = 4'hF;
        @(negedge clk);
        check("midrst_apply_busy", busy, 1);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_q", q, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready_low", cmd_ready, 0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_done", saw_done, 0);
        check("midrst_q_hold", q, 0);
        model_q = 4'h0;
        run_cmd(2'b10, 4'b0100, 4'b0100, 1'b0);
        run_cmd(2'b01, 4'b0100, 4'b0000, 1'b0);

        // Stuck-at-0 on bank bit 0.
        force dut.g_bank[0].u_ff.q = 1'b0;
        run_cmd(2'b10, 4'b0001, 4'b0000, CHK_BLD);
        release dut.g_bank[0].u_ff.q;
        @(negedge clk);
        check("after_release_q", q, 0);
        run_cmd(2'b10, 4'b0001, 4'b0001, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
